// File: rtl/host_port_pkg.sv
// Shared definitions for the host pad-bus controller: FSM states, channel-id layout
// and default geometry.
package host_port_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        TURN  = 3'd2,
        XFER  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Write channels occupy ids 0..NUM_WR-1; read channels follow at NUM_WR..
    localparam int WR_ID_BASE    = 0;
    localparam int DEF_NUM_WR    = 4;
    localparam int DEF_NUM_RD    = 2;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_TURN_CYC  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the lowest requesting id at or above the pointer wins; the
// pointer moves past the winner when advance is strobed with a live request.
module rr_arbiter #(
    parameter int N    = 6,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] ptr;

    always_comb begin
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        logic            found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(N)) begin
                sum = sum - (ID_W+1)'(N);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && |req) begin
            ptr <= (grant_id == ID_W'(N - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/host_port_arb.sv
// Host pad-bus controller: round-robin burst arbitration between GBF write/read
// channels, host request/ack handshake and pad-direction turnaround sequencing.
module host_port_arb
    import host_port_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_WR    = DEF_NUM_WR,
    parameter int NUM_RD    = DEF_NUM_RD,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int TURN_CYC  = DEF_TURN_CYC,
    parameter int CH_W      = $clog2(NUM_WR + NUM_RD)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_WR-1:0]        wr_req,
    input  logic [NUM_RD-1:0]        rd_req,
    output logic [NUM_WR-1:0]        wr_val,
    output logic [DATA_W-1:0]        wr_dat,
    output logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*DATA_W-1:0] rd_dat,
    output logic                     host_req,
    output logic                     host_dir,
    output logic [CH_W-1:0]          host_ch,
    input  logic                     host_ack,
    input  logic                     host_val,
    input  logic [DATA_W-1:0]        host_din,
    input  logic                     host_rdy,
    output logic [DATA_W-1:0]        host_dout,
    output logic                     host_dout_val,
    output logic                     pad_oe,
    output logic                     busy,
    output state_t                   fsm_state
);

    localparam int NUM_CH = NUM_WR + NUM_RD;
    localparam int CNT_W  = $clog2(BURST_LEN);
    localparam int TC_W   = $clog2(TURN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(TURN_CYC - 1);

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic              dir;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [TC_W-1:0]   tcnt, tcnt_nxt;
    logic              dcnt, dcnt_nxt;
    logic              advance;
    logic [NUM_CH-1:0] arb_grant;
    logic [CH_W-1:0]   arb_id;
    logic              wr_beat, rd_beat;
    logic [NUM_WR-1:0] wr_val_nxt;
    logic [NUM_RD-1:0] rd_q;
    logic [DATA_W-1:0] rd_mux;

    rr_arbiter #(.N(NUM_CH), .ID_W(CH_W)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      ({rd_req, wr_req}),
        .advance  (advance),
        .grant    (arb_grant),
        .grant_id (arb_id)
    );

    // Host handshake: host_req holds until host_ack is sampled high; a beat moves on
    // host_val (writes) or host_rdy (reads) only while in XFER.
    assign wr_beat = (state == XFER) && !dir && host_val;
    assign rd_beat = (state == XFER) && dir && host_rdy;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tcnt_nxt  = tcnt;
        dcnt_nxt  = dcnt;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (|{rd_req, wr_req}) begin
                    advance   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (host_ack) begin
                    state_nxt = TURN;
                    tcnt_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
            TURN: begin
                if (tcnt == TC_LAST) state_nxt = XFER;
                else tcnt_nxt = tcnt + TC_W'(1);
            end
            XFER: begin
                if (wr_beat || rd_beat) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state_nxt = dir ? DRAIN : DONE;
                        dcnt_nxt  = 1'b0;
                        tcnt_nxt  = '0;
                    end
                end
            end
            DRAIN: begin
                if (dcnt) begin
                    state_nxt = DONE;
                    tcnt_nxt  = '0;
                end else begin
                    dcnt_nxt = 1'b1;
                end
            end
            DONE: begin
                if (tcnt == TC_LAST) state_nxt = IDLE;
                else tcnt_nxt = tcnt + TC_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ch    <= '0;
            dir   <= 1'b0;
            cnt   <= '0;
            tcnt  <= '0;
            dcnt  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tcnt  <= tcnt_nxt;
            dcnt  <= dcnt_nxt;
            if (advance) begin
                ch  <= arb_id;
                dir <= |arb_grant[NUM_CH-1:NUM_WR];
            end
        end
    end

    always_comb begin
        wr_val_nxt = '0;
        rd_en      = '0;
        rd_mux     = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_val_nxt[i] = wr_beat && (ch == CH_W'(WR_ID_BASE + i));
        end
        for (int i = 0; i < NUM_RD; i++) begin
            rd_en[i] = rd_beat && (ch == CH_W'(NUM_WR + i));
            if (rd_q[i]) rd_mux = rd_dat[i*DATA_W +: DATA_W];
        end
    end

    // rd_dat arrives one cycle after rd_en; one more register stage feeds the pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_val        <= '0;
            wr_dat        <= '0;
            rd_q          <= '0;
            host_dout     <= '0;
            host_dout_val <= 1'b0;
        end else begin
            wr_val        <= wr_val_nxt;
            rd_q          <= rd_en;
            host_dout_val <= |rd_q;
            if (wr_beat) wr_dat <= host_din;
            if (|rd_q) host_dout <= rd_mux;
        end
    end

    assign host_req  = (state == REQ);
    assign host_dir  = dir;
    assign host_ch   = ch;
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign pad_oe    = dir && (((state == TURN) && (tcnt == TC_LAST)) ||
                               (state == XFER) || (state == DRAIN));

endmodule

// File: tb/tb_host_port_arb.sv
// Randomized bench for host_port_arb: a host/GBF driver with a queue-based
// reference of grants, write beats and read data, and a negedge monitor.
module tb_host_port_arb;
    import host_port_pkg::*;

    localparam int DATA_W    = 16;
    localparam int NUM_WR    = 4;
    localparam int NUM_RD    = 2;
    localparam int BURST_LEN = 16;
    localparam int TURN_CYC  = 3;
    localparam int NCH       = NUM_WR + NUM_RD;
    localparam int CH_W      = $clog2(NCH);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_WR-1:0]        wr_req;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_WR-1:0]        wr_val;
    logic [DATA_W-1:0]        wr_dat;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*DATA_W-1:0] rd_dat;
    logic                     host_req, host_dir;
    logic [CH_W-1:0]          host_ch;
    logic                     host_ack, host_val, host_rdy;
    logic [DATA_W-1:0]        host_din, host_dout;
    logic                     host_dout_val, pad_oe, busy;
    state_t                   fsm_state;

    int checks = 0;
    int failures = 0;
    int mdl_ptr = 0;
    int mdl_rd_cnt [NUM_RD] = '{default: 0};
    int gbf_cnt [NUM_RD] = '{default: 0};
    logic [DATA_W-1:0] gbf_dat [NUM_RD] = '{default: '0};
    logic [CH_W-1:0] exp_gnt_q[$];
    logic [CH_W+DATA_W-1:0] exp_wr_q[$];
    logic [DATA_W-1:0] exp_rd_q[$];
    logic req_prev = 1'b0;

    host_port_arb #(
        .DATA_W(DATA_W), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
        .BURST_LEN(BURST_LEN), .TURN_CYC(TURN_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
        .wr_val(wr_val), .wr_dat(wr_dat), .rd_en(rd_en), .rd_dat(rd_dat),
        .host_req(host_req), .host_dir(host_dir), .host_ch(host_ch),
        .host_ack(host_ack), .host_val(host_val), .host_din(host_din),
        .host_rdy(host_rdy), .host_dout(host_dout), .host_dout_val(host_dout_val),
        .pad_oe(pad_oe), .busy(busy), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_rd(input int ch, input int n);
        logic [3:0]  tag;
        logic [11:0] seq;
        tag = 4'(ch + 1);
        seq = 12'(n);
        return {tag, seq};
    endfunction

    function automatic int rr_pick(input logic [NCH-1:0] v, input int p);
        for (int i = 0; i < NCH; i++) begin
            if (v[(p + i) % NCH]) return (p + i) % NCH;
        end
        return -1;
    endfunction

    // GBF read side: data for the n-th enable of channel i appears one cycle later.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
                gbf_dat[i] <= mk_rd(i, gbf_cnt[i]);
                gbf_cnt[i] <= gbf_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_RD; i++) rd_dat[i*DATA_W +: DATA_W] = gbf_dat[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stray();
        host_val = ($urandom_range(0, 1) == 1);
        host_din = DATA_W'($urandom);
    endtask

    // Monitor: pops the expected queues whenever the DUT presents an output.
    always @(negedge clk) begin
        logic [CH_W-1:0]        eg;
        logic [CH_W+DATA_W-1:0] ew;
        if (!rst_n) begin
            req_prev = 1'b0;
        end else begin
            if (host_req && !req_prev) begin
                if (exp_gnt_q.size() == 0) begin
                    chk("grant_unexpected", 32'(host_ch), 32'hffff_ffff);
                end else begin
                    eg = exp_gnt_q.pop_front();
                    chk("host_ch", 32'(host_ch), 32'(eg));
                    chk("host_dir", 32'(host_dir), 32'(int'(eg) >= NUM_WR));
                end
            end
            req_prev = host_req;
            if (|wr_val) begin
                if (exp_wr_q.size() == 0) begin
                    chk("wr_val_unexpected", 32'(wr_val), 32'h0);
                end else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_val", 32'(wr_val), 32'(1) << ew[CH_W+DATA_W-1:DATA_W]);
                    chk("wr_dat", 32'(wr_dat), 32'(ew[DATA_W-1:0]));
                end
            end
            if (host_dout_val) begin
                if (exp_rd_q.size() == 0) begin
                    chk("dout_unexpected", 32'(host_dout), 32'hffff_ffff);
                end else begin
                    chk("host_dout", 32'(host_dout), 32'(exp_rd_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset();
        host_rdy = 1'b0;
        host_val = 1'b0;
        host_ack = 1'b0;
        wr_req   = '0;
        rd_req   = '0;
        rst_n    = 1'b0;
        #1;
        chk("rst_pad_oe", 32'(pad_oe), 0);
        chk("rst_host_req", 32'(host_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        chk("rst_dout_val", 32'(host_dout_val), 0);
        chk("rst_wr_val", 32'(wr_val), 0);
        chk("rst_host_ch", 32'(host_ch), 0);
        exp_gnt_q.delete();
        exp_wr_q.delete();
        exp_rd_q.delete();
        mdl_ptr = 0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Entered at the start of an IDLE cycle with the request vector applied; returns
    // at the start of the IDLE cycle that follows the burst.
    task automatic run_burst(input int gid, input bit last, input int ack_dly,
                             input bit pattern, input int abort_at);
        bit is_rd;
        bit v;
        int r;
        int beats;
        int cyc;
        is_rd = (gid >= NUM_WR);
        r     = gid - NUM_WR;
        stray();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_host_req", 32'(host_req), 0);
        step();
        host_val = 1'b0;
        if (last) begin
            wr_req = '0;
            rd_req = '0;
        end
        for (int j = 0; j < ack_dly; j++) begin
            @(negedge clk);
            chk("req_hold", 32'(host_req), 1);
            step();
        end
        host_ack = 1'b1;
        @(negedge clk);
        chk("req_at_ack", 32'(host_req), 1);
        step();
        host_ack = 1'b0;
        for (int k = 1; k <= TURN_CYC; k++) begin
            @(negedge clk);
            chk("turn_pad_oe", 32'(pad_oe), 32'(is_rd && k == TURN_CYC));
            chk("turn_host_req", 32'(host_req), 0);
            step();
        end
        beats = 0;
        cyc   = 0;
        while (beats < BURST_LEN) begin
            if (is_rd) begin
                v = pattern ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
                host_rdy = v;
                if (v) begin
                    exp_rd_q.push_back(mk_rd(r, mdl_rd_cnt[r]));
                    mdl_rd_cnt[r]++;
                    beats++;
                end
                @(negedge clk);
                chk("xfer_rd_pad_oe", 32'(pad_oe), 1);
                chk("rd_en", 32'(rd_en), v ? (32'(1) << r) : 32'(0));
            end else begin
                v = pattern ? 1'b1 : ($urandom_range(0, 3) != 0);
                host_val = v;
                host_din = pattern ? DATA_W'(beats) : DATA_W'($urandom);
                if (v) begin
                    exp_wr_q.push_back({CH_W'(gid), host_din});
                    beats++;
                end
                @(negedge clk);
                chk("xfer_wr_pad_oe", 32'(pad_oe), 0);
            end
            cyc++;
            step();
            if (abort_at != 0 && beats == abort_at) begin
                do_reset();
                return;
            end
        end
        host_rdy = 1'b0;
        host_val = 1'b0;
        if (is_rd) begin
            for (int k = 1; k <= 2; k++) begin
                stray();
                @(negedge clk);
                chk("drain_pad_oe", 32'(pad_oe), 1);
                if (k == 2) chk("drain_last_dout_val", 32'(host_dout_val), 1);
                step();
            end
        end
        for (int k = 1; k <= TURN_CYC; k++) begin
            stray();
            @(negedge clk);
            chk("done_pad_oe", 32'(pad_oe), 0);
            chk("done_host_req", 32'(host_req), 0);
            chk("done_busy", 32'(busy), 1);
            step();
        end
        host_val = 1'b0;
    endtask

    task automatic scenario(input logic [NUM_WR-1:0] w, input logic [NUM_RD-1:0] rq,
                            input int k, input bit pattern, input int abort_at);
        int ids[$];
        int g;
        wr_req = w;
        rd_req = rq;
        for (int b = 0; b < k; b++) begin
            g = rr_pick({rq, w}, mdl_ptr);
            mdl_ptr = (g + 1) % NCH;
            ids.push_back(g);
            exp_gnt_q.push_back(CH_W'(g));
        end
        for (int b = 0; b < k; b++) begin
            run_burst(ids[b], b == k - 1, $urandom_range(0, 3), pattern,
                      (b == k - 1) ? abort_at : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        logic [NUM_WR-1:0] w;
        logic [NUM_RD-1:0] rq;
        rst_n    = 1'b0;
        wr_req   = '0;
        rd_req   = '0;
        host_ack = 1'b0;
        host_val = 1'b0;
        host_din = '0;
        host_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_host_req", 32'(host_req), 0);
        chk("reset_pad_oe", 32'(pad_oe), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wr_val", 32'(wr_val), 0);
        chk("reset_rd_en", 32'(rd_en), 0);
        chk("reset_dout_val", 32'(host_dout_val), 0);
        chk("reset_state", 32'(fsm_state), 32'(IDLE));
        step();
        rst_n = 1'b1;
        step();

        scenario(4'hF, 2'b11, 7, 1'b0, 0);
        scenario(4'b0100, 2'b00, 1, 1'b1, 0);
        scenario(4'b0000, 2'b10, 1, 1'b1, 0);
        scenario(4'b0000, 2'b01, 1, 1'b0, 0);
        scenario(4'b0010, 2'b00, 1, 1'b0, 0);
        scenario(4'b0000, 2'b01, 1, 1'b0, 7);
        scenario(4'hF, 2'b11, 2, 1'b0, 0);

        for (int s = 0; s < 25; s++) begin
            do begin
                w  = NUM_WR'($urandom);
                rq = NUM_RD'($urandom);
            end while ({rq, w} == '0);
            scenario(w, rq, $urandom_range(1, 3), 1'b0, 0);
        end

        repeat (4) step();
        chk("grant_queue_empty", 32'(exp_gnt_q.size()), 0);
        chk("wr_queue_empty", 32'(exp_wr_q.size()), 0);
        chk("rd_queue_empty", 32'(exp_rd_q.size()), 0);
        for (int i = 0; i < NUM_RD; i++) begin
            chk("rd_en_total", 32'(gbf_cnt[i]), 32'(mdl_rd_cnt[i]));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
